// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
// The bus request struct is also used by the bus model.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FE   = 2'd1,
        MEM  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto a single memory port, one transaction at a time.
// Data has fixed priority, and a starvation counter guarantees that fetch still makes progress.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        fe_req,
    input  logic [31:2] fe_addr,
    output logic        fe_ack,
    output logic        fe_error,
    output logic [31:0] fe_data,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:2] mem_addr,
    input  logic [3:0]  mem_be,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata,

    output logic        bus_req,
    output logic        bus_we,
    output logic [31:2] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_error,
    input  logic [31:0] bus_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state, next_state;
    logic [3:0] starve_cnt;
    bus_req_t   lat;
    logic       mem_grant, fe_grant;

    // Grants are only made from IDLE. This means no grant happens in an ack cycle.
    always_comb begin
        mem_grant = (state == IDLE) && mem_req && ((starve_cnt < LIMIT) || !fe_req);
        fe_grant  = (state == IDLE) && fe_req && !mem_grant;
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        // NOTE: the default assignment up front keeps this block free of inferred latches.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (mem_grant)     next_state = MEM;
                else if (fe_grant) next_state = FE;
            end
            FE, MEM: begin
                if (bus_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus_req   = (state != IDLE);
        bus_we    = lat.we;
        bus_addr  = lat.addr;
        bus_be    = lat.be;
        bus_wdata = lat.wdata;
        fe_ack    = (state == FE) && bus_ack && fe_req && (fe_addr == lat.addr);
        mem_ack   = (state == MEM) && bus_ack;
    end

    // A fetch grant always drives a full-word read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat        <= '0;
            starve_cnt <= '0;
        end else begin
            if (mem_grant)
                lat <= '{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata};
            else if (fe_grant)
                lat <= '{we: 1'b0, addr: fe_addr, be: 4'hF, wdata: 32'h0};

            if (mem_grant && fe_req)
                starve_cnt <= (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
            else if (fe_grant || (state == IDLE && !fe_req))
                starve_cnt <= '0;
        end
    end

    // Each response is held until the next ack to the same side. A redirected fetch leaves it untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fe_data   <= '0;
            fe_error  <= 1'b0;
            mem_rdata <= '0;
            mem_error <= 1'b0;
        end else begin
            if (fe_ack) begin
                fe_data  <= bus_rdata;
                fe_error <= bus_error;
            end
            if (mem_ack) begin
                mem_rdata <= bus_rdata;
                mem_error <= bus_error;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter, plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

    logic        clk, reset_n;
    logic        fe_req, fe_ack, fe_error;
    logic [31:2] fe_addr;
    logic [31:0] fe_data;
    logic        mem_req, mem_we, mem_ack, mem_error;
    logic [31:2] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        bus_req, bus_we, bus_ack, bus_error;
    logic [31:2] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_error(fe_error), .fe_data(fe_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_error(mem_error), .mem_rdata(mem_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_error(bus_error), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fe_req;
        logic [29:0] fe_addr;
        logic        mem_req;
        logic        mem_we;
        logic [29:0] mem_addr;
        logic [3:0]  mem_be;
        logic [31:0] mem_wdata;
        logic        bus_ack;
        logic        bus_error;
        logic [31:0] bus_rdata;
        logic        x_bus_req;
        logic        x_bus_we;
        logic [29:0] x_bus_addr;
        logic [3:0]  x_bus_be;
        logic [31:0] x_bus_wdata;
        logic        x_fe_ack;
        logic        x_mem_ack;
        logic [31:0] x_fe_data;
        logic        x_fe_error;
        logic [31:0] x_mem_rdata;
        logic        x_mem_error;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        fe_req = 0; fe_addr = '0;
        mem_req = 0; mem_we = 0; mem_addr = '0; mem_be = '0; mem_wdata = '0;
        bus_ack = 0; bus_error = 0; bus_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [29:0] starve_order[6];
    int          txn;

    initial begin
        // Fields: fe_req fe_addr mem_req mem_we mem_addr mem_be mem_wdata bus_ack bus_error bus_rdata |
        //         bus_req bus_we bus_addr bus_be bus_wdata fe_ack mem_ack fe_data fe_error mem_rdata mem_error
        // Zero-wait fetch.
        vecs[0]  = '{1, 30'h20000000, 0, 0, 30'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0};
        vecs[1]  = '{1, 30'h20000000, 0, 0, 30'h0,   4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 1, 0, 30'h20000000, 4'hF, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0};
        vecs[2]  = '{0, 30'h0,        0, 0, 30'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h0,        0};
        // Simultaneous requests: data first, then fetch after one IDLE cycle.
        vecs[3]  = '{1, 30'h20000010, 1, 0, 30'h100, 4'hF, 32'h0,        0, 0, 32'h0,        0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h0,        0};
        vecs[4]  = '{1, 30'h20000010, 1, 0, 30'h100, 4'hF, 32'h0,        1, 0, 32'h11112222, 1, 0, 30'h100,      4'hF, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0,        0};
        vecs[5]  = '{1, 30'h20000010, 0, 0, 30'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h11112222, 0};
        vecs[6]  = '{1, 30'h20000010, 0, 0, 30'h0,   4'h0, 32'h0,        1, 0, 32'h33334444, 1, 0, 30'h20000010, 4'hF, 32'h0,        1, 0, 32'hDEADBEEF, 0, 32'h11112222, 0};
        vecs[7]  = '{0, 30'h0,        0, 0, 30'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'h33334444, 0, 32'h11112222, 0};
        // Write with bus error.
        vecs[8]  = '{0, 30'h0,        1, 1, 30'h200, 4'h3, 32'hCAFEF00D, 0, 0, 32'h0,        0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'h33334444, 0, 32'h11112222, 0};
        vecs[9]  = '{0, 30'h0,        1, 1, 30'h200, 4'h3, 32'hCAFEF00D, 1, 1, 32'h0,        1, 1, 30'h200,      4'h3, 32'hCAFEF00D, 0, 1, 32'h33334444, 0, 32'h11112222, 0};
        vecs[10] = '{0, 30'h0,        0, 0, 30'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'h33334444, 0, 32'h0,        1};
        // Stray bus_ack in IDLE changes nothing.
        vecs[11] = '{0, 30'h0,        0, 0, 30'h0,   4'h0, 32'h0,        1, 1, 32'h55555555, 0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'h33334444, 0, 32'h0,        1};
        vecs[12] = '{0, 30'h0,        0, 0, 30'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 30'h0,        4'h0, 32'h0,        0, 0, 32'h33334444, 0, 32'h0,        1};

        starve_order[0] = 30'h300;
        starve_order[1] = 30'h300;
        starve_order[2] = 30'h300;
        starve_order[3] = 30'h300;
        starve_order[4] = 30'h20000040;
        starve_order[5] = 30'h300;

        // Reset state.
        reset_n = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst bus_req", bus_req, 0);
        check("rst bus_we", bus_we, 0);
        check("rst bus_addr", bus_addr, 0);
        check("rst bus_be", bus_be, 0);
        check("rst bus_wdata", bus_wdata, 0);
        check("rst fe_ack", fe_ack, 0);
        check("rst mem_ack", mem_ack, 0);
        check("rst fe_data", fe_data, 0);
        check("rst fe_error", fe_error, 0);
        check("rst mem_rdata", mem_rdata, 0);
        check("rst mem_error", mem_error, 0);
        step();
        reset_n = 1;

        // Table-driven vectors, one per clock cycle.
        for (int i = 0; i < NV; i++) begin
            fe_req = vecs[i].fe_req;     fe_addr = vecs[i].fe_addr;
            mem_req = vecs[i].mem_req;   mem_we = vecs[i].mem_we;   mem_addr = vecs[i].mem_addr;
            mem_be = vecs[i].mem_be;     mem_wdata = vecs[i].mem_wdata;
            bus_ack = vecs[i].bus_ack;   bus_error = vecs[i].bus_error; bus_rdata = vecs[i].bus_rdata;
            @(negedge clk);
            check($sformatf("v%0d bus_req", i), bus_req, vecs[i].x_bus_req);
            check($sformatf("v%0d fe_ack", i), fe_ack, vecs[i].x_fe_ack);
            check($sformatf("v%0d mem_ack", i), mem_ack, vecs[i].x_mem_ack);
            check($sformatf("v%0d fe_data", i), fe_data, vecs[i].x_fe_data);
            check($sformatf("v%0d fe_error", i), fe_error, vecs[i].x_fe_error);
            check($sformatf("v%0d mem_rdata", i), mem_rdata, vecs[i].x_mem_rdata);
            check($sformatf("v%0d mem_error", i), mem_error, vecs[i].x_mem_error);
            if (vecs[i].x_bus_req) begin
                check($sformatf("v%0d bus_we", i), bus_we, vecs[i].x_bus_we);
                check($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].x_bus_addr);
                check($sformatf("v%0d bus_be", i), bus_be, vecs[i].x_bus_be);
                check($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].x_bus_wdata);
            end
            step();
        end

        // Starvation: both requests held, zero-wait bus -> M M M M F M.
        drive_idle();
        fe_req = 1; fe_addr = 30'h20000040;
        mem_req = 1; mem_addr = 30'h300; mem_be = 4'hF;
        bus_ack = 1; bus_rdata = 32'hA5A5A5A5;
        txn = 0;
        for (int cyc = 0; cyc < 40 && txn < 6; cyc++) begin
            @(negedge clk);
            if (bus_req) begin
                check($sformatf("starve t%0d bus_addr", txn), bus_addr, starve_order[txn]);
                check($sformatf("starve t%0d fe_ack", txn), fe_ack, (txn == 4) ? 1'b1 : 1'b0);
                check($sformatf("starve t%0d mem_ack", txn), mem_ack, (txn == 4) ? 1'b0 : 1'b1);
                txn++;
            end
            step();
        end
        check("starve txn count", txn, 6);
        drive_idle();

        // Redirect while FE waits on three wait states.
        fe_req = 1; fe_addr = 30'h20000004;
        step();
        @(negedge clk);
        check("redir bus_req", bus_req, 1);
        check("redir bus_addr", bus_addr, 30'h20000004);
        step();
        fe_addr = 30'h20000100;
        step();
        step();
        bus_ack = 1; bus_rdata = 32'h77777777;
        @(negedge clk);
        check("redir stale fe_ack", fe_ack, 0);
        check("redir stale bus_req", bus_req, 1);
        step();
        bus_ack = 0; bus_rdata = '0;
        @(negedge clk);
        check("redir idle bus_req", bus_req, 0);
        check("redir fe_data held", fe_data, 32'hA5A5A5A5);
        step();
        bus_ack = 1; bus_rdata = 32'h88888888;
        @(negedge clk);
        check("redir new bus_addr", bus_addr, 30'h20000100);
        check("redir new fe_ack", fe_ack, 1);
        step();
        drive_idle();
        @(negedge clk);
        check("redir new fe_data", fe_data, 32'h88888888);
        step();

        // Async reset while MEM waits.
        mem_req = 1; mem_addr = 30'h400; mem_be = 4'hF;
        step();
        @(negedge clk);
        check("rstmid bus_req before", bus_req, 1);
        #1;
        reset_n = 0;
        bus_ack = 1;
        #1;
        check("rstmid bus_req", bus_req, 0);
        check("rstmid mem_ack", mem_ack, 0);
        step();
        reset_n = 1;
        mem_req = 0;
        @(negedge clk);
        check("rstmid late ack bus_req", bus_req, 0);
        check("rstmid late ack mem_ack", mem_ack, 0);
        check("rstmid mem_rdata", mem_rdata, 0);
        check("rstmid fe_data", fe_data, 0);
        step();
        bus_ack = 0;
        fe_req = 1; fe_addr = 30'h20000200;
        step();
        @(negedge clk);
        check("rstmid regrant bus_req", bus_req, 1);
        check("rstmid regrant bus_addr", bus_addr, 30'h20000200);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single external memory port between the instruction fetch stage and the data memory stage. It latches the winning request, runs one bus transaction at a time, and returns the response with the same ack-then-data timing the fetch stage already expects. Data accesses have fixed priority over fetch, with a starvation limit that guarantees fetch progress. It sits between the pipeline stages and the memory/bus model.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win; range 1..15.
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fe_req  in  1  fetch request; may drop or change address before ack
- fe_addr  in  30 [31:2]  fetch word address
- fe_ack  out  1  fetch request accepted and completed this cycle
- fe_error  out  1  bus error for the last acked fetch; valid the cycle after fe_ack
- fe_data  out  32  read data for the last acked fetch; valid the cycle after fe_ack
- mem_req  in  1  data request; must hold stable until mem_ack
- mem_we  in  1  1 = write
- mem_addr  in  30 [31:2]  data word address
- mem_be  in  4  byte enables for writes
- mem_wdata  in  32  write data
- mem_ack  out  1  data request completed this cycle
- mem_error  out  1  bus error for the last acked data access; valid the cycle after mem_ack
- mem_rdata  out  32  read data for the last acked data access; valid the cycle after mem_ack
- bus_req  out  1  transaction active; held until bus_ack
- bus_we, bus_addr[31:2], bus_be[3:0], bus_wdata[31:0]  out  latched request fields
- bus_ack  in  1  transaction completes this cycle
- bus_error  in  1  qualified by bus_ack
- bus_rdata  in  32  qualified by bus_ack

## Operation
- States: IDLE, FE, MEM.
- IDLE: if mem_req and (starve_cnt < STARVE_LIMIT or !fe_req), go to MEM; else if fe_req, go to FE. Latch the request fields on the transition.
- FE/MEM: bus_req=1 and bus fields come from the latch. Fetch latches force bus_we=0 and bus_be=4'hF.
- On bus_ack, go to IDLE. No grant is made in the ack cycle, because the acked requester still presents its old address.
- fe_ack = FE & bus_ack & fe_req & (fe_addr == latched addr). On a mismatch or a dropped fe_req, the transaction finishes on the bus, but the result is discarded: no fe_ack, and fe_data/fe_error are not updated.
- mem_ack = MEM & bus_ack. The data side always completes.
- On ack, register bus_rdata into fe_data or mem_rdata, and bus_error into fe_error or mem_error. Hold these values until the next ack to the same side.
- starve_cnt (4 bits):
  - increments on each MEM grant made while fe_req=1, saturating at STARVE_LIMIT;
  - clears on an FE grant, and on any IDLE cycle with fe_req=0.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, starve_cnt=0;
  - bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0;
  - fe_data=0, fe_error=0, mem_rdata=0, mem_error=0.
- fe_ack and mem_ack are combinational, so they are 0 in reset.
- Latency: request seen in IDLE at edge N; bus_req is high from cycle N+1. With bus_ack in cycle M, the ack is in cycle M and the response is valid in cycle M+1. The minimum is 2 cycles per transaction with a zero-wait bus.
- Reset mid-transaction: bus_req drops immediately. No ack is produced. A later bus_ack is ignored while in IDLE.
- bus_ack while in IDLE has no effect.

## Structure
- Shared package: the arb_state_t enum (IDLE/FE/MEM) and the bus request struct (we, addr, be, wdata), which is reused by the bus model.
- Single module. No sub-module is warranted.

## Test plan
- Fetch only, zero-wait bus: fe_req=1, fe_addr=0x20000000; bus_ack in the first bus_req cycle -> bus_addr=0x20000000, bus_we=0; fe_ack in that cycle; fe_data equals bus_rdata the following cycle.
- Simultaneous requests: fe_req and mem_req both asserted in IDLE -> MEM granted first; fetch granted after mem_ack plus one IDLE cycle.
- Starvation: mem_req held continuously (re-issued after each ack), fe_req held, STARVE_LIMIT=4 -> 4 MEM transactions, then 1 FE, then MEM again.
- Redirect during fetch: fe_addr changes 0x20000004 -> 0x20000100 while FE waits on 3 wait states -> no fe_ack and fe_data unchanged; next grant drives bus_addr=0x20000100.
- Bus error on write: mem_we=1, mem_be=4'b0011, bus_error=1 with bus_ack -> mem_ack=1; mem_error=1 the next cycle; fe_error unaffected.
- Async reset asserted while MEM waits -> bus_req=0 the same cycle; no mem_ack; state=IDLE after release.
